// File: rtl/pipe_datapath_hz.sv
// pipe_datapath_hz: four-stage (ID, EX, MEM, WB) datapath for a small MIPS
// subset (add/sub/and/or/slt, addi, lw, sw, beq). It holds the register file,
// ALU, data memory, operand forwarding, load-use / RAW stall logic and branch
// flush.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instr_valid       instr/instr_pc carry a real instruction into ID
//   instr, instr_pc   instruction word and its byte address
//   stall             ID cannot accept; fetch must hold its outputs
//   branch_taken      taken beq is in MEM; fetch redirects next cycle
//   branch_target     redirect address for the taken beq
//   dbg_addr/dbg_data debug register read (combinational, write-through)
module pipe_datapath_hz #(
  parameter int XLEN       = 32,
  parameter int DMEM_DEPTH = 256,
  parameter int FWD_EN     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] instr_pc,
  output logic            stall,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  localparam int AW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  // ID/EX contents; rd_rt marks instructions that also read rt.
  typedef struct packed {
    logic            valid;
    alu_op_e         op;
    logic            use_imm;
    logic            we;
    logic            mem_rd;
    logic            mem_wr;
    logic            is_beq;
    logic            rd_rt;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dest;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } ex_t;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic            mem_rd;
    logic            mem_wr;
    logic [4:0]      dest;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sdata;
  } mem_t;

  // we is only set for a real write to a non-zero register.
  typedef struct packed {
    logic            we;
    logic [4:0]      dest;
    logic [XLEN-1:0] val;
  } wb_t;

  ex_t             ex_q, ex_d, dec_s;
  mem_t            mem_q, mem_d;
  wb_t             wb_q, wb_d;
  logic            branch_taken_q, branch_taken_d;
  logic [XLEN-1:0] branch_target_q, branch_target_d;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];
  logic [XLEN-1:0] dmem_q [DMEM_DEPTH];
  logic [XLEN-1:0] dmem_d [DMEM_DEPTH];

  logic            hazard_s, stall_s, take_s, dmem_wr_s;
  logic [AW-1:0]   mem_idx_s;
  logic [XLEN-1:0] mem_res_s, rs_op_s, rt_op_s, op_b_s, alu_s, target_s;
  logic            unused_shamt_s;

  assign unused_shamt_s = ^instr[10:6];

  // Register read with write-through of the value WB commits this cycle.
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a,
                                              input logic [XLEN-1:0] stored,
                                              input wb_t wb);
    if (a == 5'd0) rf_read = '0;
    else if (wb.we && (wb.dest == a)) rf_read = wb.val;
    else rf_read = stored;
  endfunction

  // True when decoded instruction d reads non-zero register r.
  function automatic logic reads_reg(input ex_t d, input logic [4:0] r);
    reads_reg = d.valid && (r != 5'd0) && ((d.rs == r) || (d.rd_rt && (d.rt == r)));
  endfunction

  // EX operand select: MEM result has priority over WB result.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0] r,
                                              input logic [XLEN-1:0] v,
                                              input mem_t m,
                                              input logic [XLEN-1:0] m_res,
                                              input wb_t w);
    if (m.valid && m.we && (m.dest != 5'd0) && (m.dest == r)) fwd_sel = m_res;
    else if (w.we && (w.dest == r)) fwd_sel = w.val;
    else fwd_sel = v;
  endfunction

  // Decode the instruction presented to ID and read its operands.
  always_comb begin
    dec_s        = '0;
    dec_s.op     = ALU_ADD;
    dec_s.rs     = instr[25:21];
    dec_s.rt     = instr[20:16];
    dec_s.imm    = {{(XLEN-16){instr[15]}}, instr[15:0]};
    dec_s.pc     = instr_pc;
    dec_s.rs_val = rf_read(instr[25:21], rf_q[instr[25:21]], wb_q);
    dec_s.rt_val = rf_read(instr[20:16], rf_q[instr[20:16]], wb_q);
    case (instr[31:26])
      6'h00: begin
        dec_s.valid = 1'b1;
        dec_s.we    = 1'b1;
        dec_s.rd_rt = 1'b1;
        dec_s.dest  = instr[15:11];
        case (instr[5:0])
          6'h20:   dec_s.op = ALU_ADD;
          6'h22:   dec_s.op = ALU_SUB;
          6'h24:   dec_s.op = ALU_AND;
          6'h25:   dec_s.op = ALU_OR;
          6'h2A:   dec_s.op = ALU_SLT;
          default: dec_s.valid = 1'b0;
        endcase
      end
      6'h08: begin
        dec_s.valid = 1'b1; dec_s.we = 1'b1; dec_s.use_imm = 1'b1; dec_s.dest = instr[20:16];
      end
      6'h23: begin
        dec_s.valid = 1'b1; dec_s.we = 1'b1; dec_s.mem_rd = 1'b1; dec_s.use_imm = 1'b1;
        dec_s.dest  = instr[20:16];
      end
      6'h2B: begin
        dec_s.valid = 1'b1; dec_s.mem_wr = 1'b1; dec_s.use_imm = 1'b1; dec_s.rd_rt = 1'b1;
      end
      6'h04: begin
        dec_s.valid = 1'b1; dec_s.is_beq = 1'b1; dec_s.rd_rt = 1'b1;
      end
      default: dec_s.valid = 1'b0;
    endcase
    // Unknown encodings and empty fetch slots travel as bubbles.
    if (!(instr_valid && dec_s.valid)) begin
      dec_s.valid  = 1'b0;
      dec_s.we     = 1'b0;
      dec_s.mem_rd = 1'b0;
      dec_s.mem_wr = 1'b0;
      dec_s.is_beq = 1'b0;
      dec_s.rd_rt  = 1'b0;
    end else begin
      dec_s.valid  = 1'b1;
    end
  end

  // Hazard detection; a taken branch squashes ID so it never stalls.
  always_comb begin
    if (FWD_EN != 0) begin
      hazard_s = ex_q.valid && ex_q.mem_rd && reads_reg(dec_s, ex_q.dest);
    end else begin
      hazard_s = (ex_q.valid && ex_q.we && reads_reg(dec_s, ex_q.dest)) ||
                 (mem_q.valid && mem_q.we && reads_reg(dec_s, mem_q.dest));
    end
    stall_s = hazard_s && !branch_taken_q;
  end

  // MEM-stage result: lw data is read combinationally so it can be forwarded.
  always_comb begin
    mem_idx_s = mem_q.alu[AW+1:2];
    mem_res_s = mem_q.mem_rd ? dmem_q[mem_idx_s] : mem_q.alu;
    dmem_wr_s = mem_q.valid && mem_q.mem_wr && !rst;
  end

  // EX stage: operand forwarding, ALU and branch resolution.
  always_comb begin
    if (FWD_EN != 0) begin
      rs_op_s = fwd_sel(ex_q.rs, ex_q.rs_val, mem_q, mem_res_s, wb_q);
      rt_op_s = ex_q.rd_rt ? fwd_sel(ex_q.rt, ex_q.rt_val, mem_q, mem_res_s, wb_q) : ex_q.rt_val;
    end else begin
      rs_op_s = ex_q.rs_val;
      rt_op_s = ex_q.rt_val;
    end
    op_b_s = ex_q.use_imm ? ex_q.imm : rt_op_s;
    case (ex_q.op)
      ALU_ADD: alu_s = rs_op_s + op_b_s;
      ALU_SUB: alu_s = rs_op_s - op_b_s;
      ALU_AND: alu_s = rs_op_s & op_b_s;
      ALU_OR:  alu_s = rs_op_s | op_b_s;
      ALU_SLT: alu_s = {{(XLEN-1){1'b0}}, ($signed(rs_op_s) < $signed(op_b_s))};
      default: alu_s = '0;
    endcase
    target_s = ex_q.pc + {{(XLEN-3){1'b0}}, 3'd4} + (ex_q.imm << 2);
    // An EX instruction behind a taken branch is itself squashed.
    take_s   = ex_q.valid && ex_q.is_beq && (rs_op_s == rt_op_s) && !branch_taken_q;
  end

  // Next-state for pipeline registers, register file and data memory.
  always_comb begin
    ex_d            = (branch_taken_q || stall_s) ? '0 : dec_s;
    mem_d.valid     = ex_q.valid && !branch_taken_q;
    mem_d.we        = ex_q.we;
    mem_d.mem_rd    = ex_q.mem_rd;
    mem_d.mem_wr    = ex_q.mem_wr;
    mem_d.dest      = ex_q.dest;
    mem_d.alu       = alu_s;
    mem_d.sdata     = rt_op_s;
    wb_d.we         = mem_q.valid && mem_q.we && (mem_q.dest != 5'd0);
    wb_d.dest       = mem_q.dest;
    wb_d.val        = mem_res_s;
    branch_taken_d  = take_s;
    branch_target_d = take_s ? target_s : branch_target_q;
    for (int i = 0; i < 32; i++) begin
      rf_d[i] = (wb_q.we && (wb_q.dest == i[4:0])) ? wb_q.val : rf_q[i];
    end
    for (int i = 0; i < DMEM_DEPTH; i++) begin
      dmem_d[i] = (dmem_wr_s && (mem_idx_s == i[AW-1:0])) ? mem_q.sdata : dmem_q[i];
    end
  end

  // Pipeline, branch and register-file state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q            <= '0;
      mem_q           <= '0;
      wb_q            <= '0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
      rf_q            <= '{default: '0};
    end else begin
      ex_q            <= ex_d;
      mem_q           <= mem_d;
      wb_q            <= wb_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
      rf_q            <= rf_d;
    end
  end

  // Data memory has no reset; writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    dmem_q <= dmem_d;
  end

  // Output drive.
  always_comb begin
    stall         = stall_s;
    branch_taken  = branch_taken_q;
    branch_target = branch_target_q;
    dbg_data      = rf_read(dbg_addr, rf_q[dbg_addr], wb_q);
  end
endmodule

// File: tb/tb_pipe_datapath_hz.sv
module tb_pipe_datapath_hz;
  logic        clk = 1'b0;
  logic        rst, instr_valid, sel, chk_req;
  logic [31:0] instr, instr_pc, pc;
  logic [4:0]  dbg_addr;
  logic        v0, v1, stall0, stall1, bt0, bt1;
  logic [31:0] tgt0, tgt1, dd0, dd1;
  logic        cur_stall, cur_bt;
  logic [31:0] cur_tgt, cur_dd;
  int          total = 0, bad = 0, stall_cnt = 0, base;

  typedef struct { int kind; string name; logic [33:0] exp; } chk_t;
  chk_t        exp_q[$];
  logic [31:0] br_q[$];

  always #5 clk = ~clk;

  assign v0 = instr_valid & ~sel;
  assign v1 = instr_valid & sel;
  assign cur_stall = sel ? stall1 : stall0;
  assign cur_bt    = sel ? bt1 : bt0;
  assign cur_tgt   = sel ? tgt1 : tgt0;
  assign cur_dd    = sel ? dd1 : dd0;

  pipe_datapath_hz #(.XLEN(32), .DMEM_DEPTH(256), .FWD_EN(1)) dut0 (
    .clk(clk), .rst(rst), .instr_valid(v0), .instr(instr), .instr_pc(instr_pc),
    .stall(stall0), .branch_taken(bt0), .branch_target(tgt0),
    .dbg_addr(dbg_addr), .dbg_data(dd0));

  pipe_datapath_hz #(.XLEN(32), .DMEM_DEPTH(256), .FWD_EN(0)) dut1 (
    .clk(clk), .rst(rst), .instr_valid(v1), .instr(instr), .instr_pc(instr_pc),
    .stall(stall1), .branch_taken(bt1), .branch_target(tgt1),
    .dbg_addr(dbg_addr), .dbg_data(dd1));

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Monitor: counts stall cycles, checks every branch_taken and every check request.
  initial begin : monitor
    chk_t        c;
    logic [33:0] got;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (cur_stall === 1'b1) stall_cnt++;
      if (cur_bt === 1'b1) begin
        total++;
        if (br_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_branch got target=%h required no branch", cur_tgt);
        end else begin
          e = br_q.pop_front();
          if (cur_tgt !== e) begin
            bad++;
            $display("FAIL branch_target got=%h required=%h", cur_tgt, e);
          end
        end
      end
      if (chk_req === 1'b1 && exp_q.size() != 0) begin
        c = exp_q.pop_front();
        case (c.kind)
          0:       got = {2'b00, cur_dd};
          1:       got = 34'(stall_cnt);
          default: got = {cur_stall, cur_bt, cur_tgt};
        endcase
        total++;
        if (got !== c.exp) begin
          bad++;
          $display("FAIL %s got=%0h required=%0h", c.name, got, c.exp);
        end
      end
    end
  end

  task automatic push_chk(input int kind, input string nm, input logic [33:0] v);
    chk_t c;
    c.kind = kind; c.name = nm; c.exp = v;
    exp_q.push_back(c);
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic check_reg(input string nm, input logic [4:0] a, input logic [31:0] v);
    dbg_addr = a;
    push_chk(0, nm, {2'b00, v});
  endtask

  task automatic check_stall(input string nm, input int n);
    push_chk(1, nm, 34'(base + n));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one instruction and hold it until ID accepts it.
  task automatic go(input logic [31:0] i);
    int n = 0;
    instr = i; instr_pc = pc; instr_valid = 1'b1;
    @(negedge clk);
    while (cur_stall === 1'b1 && n < 20) begin n++; @(negedge clk); end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL stall_timeout got=stuck required=accept pc=%h", pc);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    pc = pc + 32'd4;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; instr_pc = 32'd0; pc = 32'd0;
    dbg_addr = 5'd0; chk_req = 1'b0; sel = 1'b0;
    idle(2);
    rst = 1'b0;
    push_chk(2, "reset_outputs", 34'd0);
    check_reg("reset_r31", 5'd31, 32'd0);

    // Back-to-back RAW through forwarding.
    base = stall_cnt;
    go(itype(6'h08, 5'd1, 5'd0, 16'd5));
    go(itype(6'h08, 5'd2, 5'd0, 16'd7));
    go(rtype(6'h20, 5'd3, 5'd1, 5'd2));
    idle(3);
    check_stall("fwd_raw_stalls", 0);
    check_reg("r1_addi", 5'd1, 32'd5);
    check_reg("r3_fwd_add", 5'd3, 32'd12);

    // Store, load, then load-use.
    go(itype(6'h2B, 5'd0, 5'd0, 16'd12));
    go(itype(6'h2B, 5'd3, 5'd0, 16'd8));
    base = stall_cnt;
    go(itype(6'h23, 5'd4, 5'd0, 16'd8));
    go(rtype(6'h20, 5'd5, 5'd4, 5'd4));
    idle(3);
    check_stall("load_use_stalls", 1);
    check_reg("r4_lw", 5'd4, 32'd12);
    check_reg("r5_load_use", 5'd5, 32'd24);

    // Remaining ALU ops and a not-taken beq.
    go(rtype(6'h22, 5'd14, 5'd1, 5'd2));
    go(rtype(6'h2A, 5'd15, 5'd14, 5'd1));
    go(rtype(6'h24, 5'd16, 5'd1, 5'd2));
    go(rtype(6'h25, 5'd17, 5'd1, 5'd2));
    go(itype(6'h04, 5'd2, 5'd1, 16'd1));
    go(itype(6'h08, 5'd18, 5'd14, 16'd10));
    idle(3);
    check_reg("r14_sub", 5'd14, 32'hFFFF_FFFE);
    check_reg("r15_slt_signed", 5'd15, 32'd1);
    check_reg("r16_and", 5'd16, 32'd5);
    check_reg("r17_or", 5'd17, 32'd7);
    check_reg("r18_addi_neg", 5'd18, 32'd8);

    // Taken beq at 0x40; the two shadow instructions must vanish.
    br_q.push_back(32'h0000_0050);
    pc = 32'h40;
    go(itype(6'h04, 5'd1, 5'd1, 16'd3));
    go(itype(6'h08, 5'd7, 5'd0, 16'd1));
    go(itype(6'h2B, 5'd1, 5'd0, 16'd12));
    pc = 32'h50;
    go(itype(6'h08, 5'd9, 5'd0, 16'd2));
    go(itype(6'h23, 5'd13, 5'd0, 16'd12));
    idle(3);
    check_reg("r7_squashed", 5'd7, 32'd0);
    check_reg("r9_target", 5'd9, 32'd2);
    check_reg("r13_sw_squashed", 5'd13, 32'd0);

    // Load-use pending in the branch_taken cycle: no stall.
    br_q.push_back(32'h0000_006C);
    base = stall_cnt;
    pc = 32'h60;
    go(itype(6'h04, 5'd0, 5'd0, 16'd2));
    go(itype(6'h23, 5'd10, 5'd0, 16'd8));
    go(rtype(6'h20, 5'd11, 5'd10, 5'd10));
    pc = 32'h6C;
    go(itype(6'h08, 5'd12, 5'd0, 16'd4));
    idle(3);
    check_stall("branch_over_stall", 0);
    check_reg("r10_squashed", 5'd10, 32'd0);
    check_reg("r11_squashed", 5'd11, 32'd0);
    check_reg("r12_target", 5'd12, 32'd4);

    // r0 is never written nor forwarded.
    go(itype(6'h08, 5'd6, 5'd0, 16'd3));
    idle(3);
    check_reg("r6_pre", 5'd6, 32'd3);
    base = stall_cnt;
    go(itype(6'h08, 5'd0, 5'd0, 16'd9));
    go(rtype(6'h20, 5'd6, 5'd0, 5'd0));
    idle(3);
    check_stall("r0_no_stall", 0);
    check_reg("r6_from_r0", 5'd6, 32'd0);
    check_reg("r0_zero", 5'd0, 32'd0);

    // Reset while lw sits in MEM.
    go(itype(6'h23, 5'd12, 5'd0, 16'd8));
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    push_chk(2, "rst_outputs", 34'd0);
    check_reg("rst_r12", 5'd12, 32'd0);
    idle(3);
    check_reg("rst_r12_late", 5'd12, 32'd0);
    check_reg("rst_r3", 5'd3, 32'd0);

    // No-forwarding instance: RAW and load-use resolved by stalling.
    sel = 1'b1;
    base = stall_cnt;
    go(itype(6'h08, 5'd1, 5'd0, 16'd5));
    go(itype(6'h08, 5'd2, 5'd0, 16'd7));
    go(rtype(6'h20, 5'd3, 5'd1, 5'd2));
    idle(3);
    check_stall("nofwd_raw_stalls", 2);
    check_reg("nofwd_r3", 5'd3, 32'd12);
    go(itype(6'h2B, 5'd3, 5'd0, 16'd8));
    go(itype(6'h23, 5'd4, 5'd0, 16'd8));
    base = stall_cnt;
    go(rtype(6'h20, 5'd5, 5'd4, 5'd4));
    idle(3);
    check_stall("nofwd_load_stalls", 2);
    check_reg("nofwd_r5", 5'd5, 32'd24);

    total++;
    if (br_q.size() != 0) begin
      bad++;
      $display("FAIL missing_branches got=%0d pending required=0", br_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
